// File: rtl/bpu_update_arbiter.sv
// Update-port sequencer for the 2-bit branch predictor: two private FIFOs
// drained round-robin, with enable/drain FSM, flush and saturating stats.
module bpu_update_arbiter #(
    parameter int DEPTH = 2,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          flush,
    input  logic          clr_stats,
    input  logic          rq0_valid,
    output logic          rq0_ready,
    input  logic [7:0]    rq0_pc,
    input  logic          rq0_taken,
    input  logic          rq0_pred,
    input  logic          rq1_valid,
    output logic          rq1_ready,
    input  logic [7:0]    rq1_pc,
    input  logic          rq1_taken,
    input  logic          rq1_pred,
    output logic          bp_valid,
    output logic [7:0]    bp_pc,
    output logic          bp_taken,
    output logic [CW-1:0] upd_count,
    output logic [CW-1:0] miss_count,
    output logic          busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   L_FULL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] L_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_DIS,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // record layout: {pc, taken, pred}
    logic [9:0]    r_mem [2][DEPTH];
    logic [AW-1:0] r_wp  [2];
    logic [AW-1:0] r_rp  [2];
    logic [AW:0]   r_cnt [2];
    logic          r_rr;

    logic          r_bp_valid;
    logic [7:0]    r_bp_pc;
    logic          r_bp_taken;
    logic [CW-1:0] r_upd;
    logic [CW-1:0] r_miss;
    logic          r_busy;

    logic [9:0]    w_in_rec [2];
    logic [1:0]    w_in_valid;
    logic [1:0]    w_nempty;
    logic [1:0]    w_full;
    logic [1:0]    w_ready;
    logic [1:0]    w_push;
    logic [1:0]    w_pop;
    logic          w_issue;
    logic          w_gnt;
    logic [9:0]    w_rec;
    logic          w_miss;
    logic [AW:0]   w_cnt_nxt [2];

    assign w_in_rec[0] = {rq0_pc, rq0_taken, rq0_pred};
    assign w_in_rec[1] = {rq1_pc, rq1_taken, rq1_pred};
    assign w_in_valid  = {rq1_valid, rq0_valid};

    always_comb begin
        w_nempty = 2'b00;
        w_full   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            w_nempty[i] = (r_cnt[i] != '0);
            w_full[i]   = (r_cnt[i] == L_FULL);
        end
        w_ready = {2{r_state == S_RUN}} & ~w_full;
        w_push  = w_in_valid & w_ready & {2{~flush}};

        w_issue = 1'b0;
        w_gnt   = 1'b0;
        if (r_state != S_DIS && !flush && |w_nempty) begin
            w_issue = 1'b1;
            w_gnt   = (&w_nempty) ? r_rr : w_nempty[1];
        end
        w_pop  = w_issue ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;
        w_rec  = r_mem[w_gnt][r_rp[w_gnt]];
        w_miss = w_rec[1] ^ w_rec[0];

        for (int i = 0; i < 2; i++) begin
            w_cnt_nxt[i] = '0;
            if (!flush)
                w_cnt_nxt[i] = r_cnt[i] + (AW+1)'(w_push[i])
                                        - (AW+1)'(w_pop[i]);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_DIS:   if (en) w_state_nxt = S_RUN;
            S_RUN:   if (!en) w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (en)
                    w_state_nxt = S_RUN;
                else if (!(|w_nempty))
                    w_state_nxt = S_DIS;
            end
            default: w_state_nxt = S_DIS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= S_DIS;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                r_wp[i]  <= '0;
                r_rp[i]  <= '0;
                r_cnt[i] <= '0;
            end
            r_rr <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (flush) begin
                    r_wp[i] <= '0;
                    r_rp[i] <= '0;
                end else begin
                    if (w_push[i]) r_wp[i] <= r_wp[i] + AW'(1);
                    if (w_pop[i])  r_rp[i] <= r_rp[i] + AW'(1);
                end
                r_cnt[i] <= w_cnt_nxt[i];
            end
            if (flush)
                r_rr <= 1'b0;
            else if (w_issue)
                r_rr <= ~w_gnt;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (w_push[i]) r_mem[i][r_wp[i]] <= w_in_rec[i];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bp_valid <= 1'b0;
            r_bp_pc    <= '0;
            r_bp_taken <= 1'b0;
            r_upd      <= '0;
            r_miss     <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_bp_valid <= w_issue;
            if (w_issue) begin
                r_bp_pc    <= w_rec[9:2];
                r_bp_taken <= w_rec[1];
            end
            // clear wins over a coincident increment
            if (clr_stats) begin
                r_upd  <= '0;
                r_miss <= '0;
            end else if (w_issue) begin
                if (!(&r_upd))
                    r_upd <= r_upd + L_ONE;
                if (w_miss && !(&r_miss))
                    r_miss <= r_miss + L_ONE;
            end
            r_busy <= (w_state_nxt != S_DIS) | (|w_cnt_nxt[0])
                    | (|w_cnt_nxt[1]);
        end
    end

    assign rq0_ready  = w_ready[0];
    assign rq1_ready  = w_ready[1];
    assign bp_valid   = r_bp_valid;
    assign bp_pc      = r_bp_pc;
    assign bp_taken   = r_bp_taken;
    assign upd_count  = r_upd;
    assign miss_count = r_miss;
    assign busy       = r_busy;

endmodule

// File: tb/tb_bpu_update_arbiter.sv
// Bench for bpu_update_arbiter: directed vector table, corner sequences,
// then random traffic against a queue-based reference model.
module tb_bpu_update_arbiter;

    localparam int DEPTH = 2;
    localparam int CW    = 4;
    localparam int MAXC  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, en, flush, clr_stats;
    logic          rq0_valid, rq0_taken, rq0_pred;
    logic          rq1_valid, rq1_taken, rq1_pred;
    logic [7:0]    rq0_pc, rq1_pc;
    logic          rq0_ready, rq1_ready;
    logic          bp_valid, bp_taken, busy;
    logic [7:0]    bp_pc;
    logic [CW-1:0] upd_count, miss_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bpu_update_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .clr_stats(clr_stats),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_pc(rq0_pc),
        .rq0_taken(rq0_taken), .rq0_pred(rq0_pred),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_pc(rq1_pc),
        .rq1_taken(rq1_taken), .rq1_pred(rq1_pred),
        .bp_valid(bp_valid), .bp_pc(bp_pc), .bp_taken(bp_taken),
        .upd_count(upd_count), .miss_count(miss_count), .busy(busy)
    );

    // reference model: mode 0=disabled 1=run 2=drain
    int         m_mode;
    bit         m_known = 0;
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    int         m_next;
    bit         m_bpv, m_bpt;
    logic [7:0] m_bpc;
    int         m_upd, m_miss;
    bit         m_busy;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit m_rdy(int n);
        int sz = (n == 0) ? q0.size() : q1.size();
        return (m_mode == 1) && (sz < DEPTH);
    endfunction

    task automatic model_step();
        bit r0, r1, e0, e1;
        int g;
        logic [9:0] rec;
        if (!reset) begin
            m_mode = 0; q0.delete(); q1.delete(); m_next = 0;
            m_bpv = 0; m_bpc = 0; m_bpt = 0;
            m_upd = 0; m_miss = 0; m_busy = 0; m_known = 1;
            return;
        end
        r0 = m_rdy(0);
        r1 = m_rdy(1);
        e0 = (q0.size() == 0);
        e1 = (q1.size() == 0);
        g = -1;
        if (m_mode != 0 && !flush) begin
            if (!e0 && !e1) g = m_next;
            else if (!e0)   g = 0;
            else if (!e1)   g = 1;
        end
        m_bpv = (g >= 0);
        if (g >= 0) begin
            rec = (g == 0) ? q0.pop_front() : q1.pop_front();
            m_bpc = rec[9:2];
            m_bpt = rec[1];
            if (m_upd < MAXC) m_upd++;
            if (rec[1] != rec[0] && m_miss < MAXC) m_miss++;
            m_next = 1 - g;
        end
        if (clr_stats) begin
            m_upd = 0; m_miss = 0;
        end
        if (flush) begin
            q0.delete(); q1.delete(); m_next = 0;
        end else begin
            if (rq0_valid && r0) q0.push_back({rq0_pc, rq0_taken, rq0_pred});
            if (rq1_valid && r1) q1.push_back({rq1_pc, rq1_taken, rq1_pred});
        end
        case (m_mode)
            0: if (en) m_mode = 1;
            1: if (!en) m_mode = 2;
            default: begin
                if (en) m_mode = 1;
                else if (e0 && e1) m_mode = 0;
            end
        endcase
        m_busy = (m_mode != 0) || (q0.size() != 0) || (q1.size() != 0);
    endtask

    task automatic tick();
        if (m_known) begin
            chk("rq0_ready", rq0_ready, m_rdy(0));
            chk("rq1_ready", rq1_ready, m_rdy(1));
        end
        model_step();
        @(posedge clk);
        #1;
        chk("bp_valid", bp_valid, m_bpv);
        chk("bp_pc", bp_pc, m_bpc);
        chk("bp_taken", bp_taken, m_bpt);
        chk("upd_count", upd_count, m_upd);
        chk("miss_count", miss_count, m_miss);
        chk("busy", busy, m_busy);
    endtask

    task automatic idle();
        flush = 0; clr_stats = 0;
        rq0_valid = 0; rq0_pc = 0; rq0_taken = 0; rq0_pred = 0;
        rq1_valid = 0; rq1_pc = 0; rq1_taken = 0; rq1_pred = 0;
    endtask

    task automatic do_reset();
        idle();
        en = 0;
        reset = 0;
        tick();
        reset = 1;
    endtask

    task automatic push_both(int n);
        for (int k = 0; k < n; k++) begin
            rq0_valid = 1; rq0_pc = 8'h30 + 8'(k); rq0_taken = 1; rq0_pred = 1;
            rq1_valid = 1; rq1_pc = 8'h40 + 8'(k); rq1_taken = 0; rq1_pred = 1;
            tick();
        end
        idle();
    endtask

    typedef struct {
        logic       en, flush, v0;
        logic [7:0] pc0;
        logic       t0, p0, v1;
        logic [7:0] pc1;
        logic       t1, p1;
        logic       r0, r1, bpv;
        logic [7:0] bpc;
        logic       bpt;
        int         upd, miss;
        logic       bsy;
    } vec_t;

    vec_t tbl[14];

    initial begin
        bit done;
        int saved_upd, saved_miss;

        tbl[0]  = '{1,0,0,8'h00,0,0,0,8'h00,0,0, 0,0, 0,8'h00,0,0,0,1};
        tbl[1]  = '{1,0,1,8'h00,1,0,0,8'h00,0,0, 1,1, 0,8'h00,0,0,0,1};
        tbl[2]  = '{1,0,0,8'h00,0,0,0,8'h00,0,0, 1,1, 1,8'h00,1,1,1,1};
        tbl[3]  = '{1,0,0,8'h00,0,0,0,8'h00,0,0, 1,1, 0,8'h00,1,1,1,1};
        tbl[4]  = '{1,1,0,8'h00,0,0,0,8'h00,0,0, 1,1, 0,8'h00,1,1,1,1};
        tbl[5]  = '{1,0,1,8'h10,0,0,1,8'h20,1,1, 1,1, 0,8'h00,1,1,1,1};
        tbl[6]  = '{1,0,1,8'h10,0,0,1,8'h20,1,1, 1,1, 1,8'h10,0,2,1,1};
        tbl[7]  = '{1,0,1,8'h10,0,0,1,8'h20,1,1, 1,0, 1,8'h20,1,3,1,1};
        tbl[8]  = '{1,0,1,8'h10,0,0,1,8'h20,1,1, 0,1, 1,8'h10,0,4,1,1};
        tbl[9]  = '{1,0,1,8'h10,0,0,1,8'h20,1,1, 1,0, 1,8'h20,1,5,1,1};
        tbl[10] = '{1,0,0,8'h00,0,0,0,8'h00,0,0, 0,1, 1,8'h10,0,6,1,1};
        tbl[11] = '{1,0,0,8'h00,0,0,0,8'h00,0,0, 1,1, 1,8'h20,1,7,1,1};
        tbl[12] = '{1,0,0,8'h00,0,0,0,8'h00,0,0, 1,1, 1,8'h10,0,8,1,1};
        tbl[13] = '{1,0,0,8'h00,0,0,0,8'h00,0,0, 1,1, 0,8'h10,0,8,1,1};

        idle();
        en = 0;
        reset = 0;
        tick();
        tick();
        chk("rst_bp_valid", bp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready0", rq0_ready, 0);
        reset = 1;

        foreach (tbl[i]) begin
            en = tbl[i].en; flush = tbl[i].flush; clr_stats = 0;
            rq0_valid = tbl[i].v0; rq0_pc = tbl[i].pc0;
            rq0_taken = tbl[i].t0; rq0_pred = tbl[i].p0;
            rq1_valid = tbl[i].v1; rq1_pc = tbl[i].pc1;
            rq1_taken = tbl[i].t1; rq1_pred = tbl[i].p1;
            chk("tbl_ready0", rq0_ready, tbl[i].r0);
            chk("tbl_ready1", rq1_ready, tbl[i].r1);
            tick();
            chk("tbl_bp_valid", bp_valid, tbl[i].bpv);
            chk("tbl_bp_pc", bp_pc, tbl[i].bpc);
            chk("tbl_bp_taken", bp_taken, tbl[i].bpt);
            chk("tbl_upd", upd_count, tbl[i].upd);
            chk("tbl_miss", miss_count, tbl[i].miss);
            chk("tbl_busy", busy, tbl[i].bsy);
        end
        idle();

        // drain after en drops, then quiesce
        do_reset();
        en = 1; tick();
        push_both(2);
        en = 0; tick();
        chk("drain_ready0", rq0_ready, 0);
        chk("drain_ready1", rq1_ready, 0);
        done = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            tick();
            if (!busy) done = 1;
        end
        chk("drain_quiesce", done, 1);

        // re-enable mid-drain
        en = 1; tick();
        push_both(2);
        en = 0; tick();
        en = 1; tick();
        chk("reenable_ready0", rq0_ready, 1);
        tick(); tick(); tick();

        // flush with a push in the same cycle
        push_both(2);
        saved_upd = int'(upd_count);
        saved_miss = int'(miss_count);
        flush = 1; rq0_valid = 1; rq0_pc = 8'h77;
        tick();
        idle();
        chk("flush_bp_valid", bp_valid, 0);
        chk("flush_upd", upd_count, saved_upd);
        tick();
        chk("flush_drop_new", bp_valid, 0);
        chk("flush_miss", miss_count, saved_miss);

        // saturation then clear against a coincident issue
        do_reset();
        en = 1; tick();
        for (int k = 0; k < MAXC + 1; k++) begin
            rq0_valid = 1; rq0_pc = 8'(k); rq0_taken = 1; rq0_pred = 0;
            tick();
        end
        idle();
        tick();
        chk("sat_upd", upd_count, MAXC);
        chk("sat_miss", miss_count, MAXC);
        rq0_valid = 1; rq0_pc = 8'hA5; rq0_taken = 0; rq0_pred = 1;
        tick();
        idle();
        clr_stats = 1;
        tick();
        clr_stats = 0;
        chk("clr_issue_valid", bp_valid, 1);
        chk("clr_upd", upd_count, 0);
        chk("clr_miss", miss_count, 0);

        // reset with work in flight
        push_both(2);
        reset = 0;
        tick();
        reset = 1;
        chk("midrst_bp_valid", bp_valid, 0);
        chk("midrst_bp_pc", bp_pc, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready1", rq1_ready, 0);

        // random traffic
        en = 1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(15) == 0) en = ~en;
            flush     = ($urandom_range(31) == 0);
            clr_stats = ($urandom_range(31) == 0);
            reset     = ($urandom_range(255) != 0);
            rq0_valid = ($urandom_range(9) < 6);
            rq0_pc    = 8'($urandom);
            rq0_taken = 1'($urandom);
            rq0_pred  = 1'($urandom);
            rq1_valid = ($urandom_range(9) < 5);
            rq1_pc    = 8'($urandom);
            rq1_taken = 1'($urandom);
            rq1_pred  = 1'($urandom);
            tick();
        end
        reset = 1;
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
